write_iq: RTL
=============

// Module: write_iq
// PURPOSE
//  Inverse of the IQ ingest stage: pops one fixed-point I sample and one Q sample
//  from two 32-bit FIFOs and dequantizes each back to an integer sample.
//  Packs both into one 64-bit word in the halfword-swapped raw IQ layout.
//  Pushes the word to a single output FIFO.
//  Sits at the tail of the IQ test/loopback path, feeding the raw IQ file/DMA writer.
// PARAMETERS
//  FRAC_BITS   10   fractional bits of the fixed-point format; must match GLOBALS quantize shift (>=1)
//  COUNT_W     32   width of sample_count
// PORTS
//  clock         in   1        system clock; all state updates on rising edge
//  reset         in   1        asynchronous, active-low reset (asserts on 0, independent of clock)
//  inI_rd_en     out  1        pop strobe, I FIFO (FWFT: inI_dout valid while !inI_empty)
//  inI_empty     in   1        I FIFO empty
//  inI_dout      in   32       signed fixed-point I sample
//  inQ_rd_en     out  1        pop strobe, Q FIFO (FWFT)
//  inQ_empty     in   1        Q FIFO empty
//  inQ_dout      in   32       signed fixed-point Q sample
//  out_wr_en     out  1        push strobe, output FIFO
//  out_full      in   1        output FIFO full
//  out_din       out  64       packed IQ word
//  sample_count  out  COUNT_W  number of words pushed since reset
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=S_READ; I_r, Q_r, word_r = 0; sample_count=0
//   - inI_rd_en, inQ_rd_en, out_wr_en = 0 and out_din=0 while reset is low
//  Strobes rd_en/wr_en are combinational from state and flags.
//  out_din = word_r when out_wr_en=1, else 0.
//  FSM (3 states; illegal encodings go to S_READ with I_r/Q_r cleared):
//   S_READ:  if !inI_empty && !inQ_empty:
//            - assert inI_rd_en and inQ_rd_en in the same cycle
//            - I_r<=inI_dout, Q_r<=inQ_dout; -> S_CALC
//            Otherwise: no pop, stay. Never pop only one FIFO, so the I/Q pairing is preserved.
//   S_CALC:  word_r <= pack(deq(I_r), deq(Q_r)); -> S_WRITE. No strobes.
//   S_WRITE: if !out_full: out_wr_en=1, sample_count++ (wraps at 2^COUNT_W), -> S_READ
//            Otherwise: hold word_r, stay; input FIFOs are not popped.
//  Latency: pop cycle N -> push earliest at cycle N+2. Max throughput 1 word / 3 clocks.
//  Dequantize: deq(x) = (sext33(x) + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
//   - round half toward +inf, arithmetic shift
//   - 33-bit intermediate, so there is no overflow at x=0x7FFFFFFF; low 32 bits kept
//  Pack (halfword swap, inverse of ingest):
//   - out[63:48]=dI[15:0], out[47:32]=dI[31:16]
//   - out[31:16]=dQ[15:0], out[15:0]=dQ[31:16]
//  Boundaries:
//   - one input FIFO empty: wait with no pop on either
//   - out_full held indefinitely: word held stable, no loss or duplication
//   - out_full deasserts: push in that same cycle
//   - async reset mid-S_WRITE: held word is discarded, count returns to 0
//  Round-trip: for |sample| < 2^(31-FRAC_BITS), ingest followed by write_iq reproduces
//   the original 64-bit word exactly.
// TESTING (FRAC_BITS=10)
//  1 I=0x00000400, Q=0xFFFFFC00 -> out_din=0x0001_0000_FFFF_FFFF, pushed 2 clocks after pop, count=1
//  2 Rounding: I=0x00000200 -> dI=1; I=0xFFFFFE00 -> dI=0; I=0xFFFFFDFF -> dI=-1 (0xFFFFFFFF)
//  3 I FIFO holds 3 samples, Q empty for 20 clocks -> no rd_en on either; first pop when Q is written
//  4 out_full high 50 clocks in S_WRITE -> no pops or pushes; word pushed once on deassert; count +1
//  5 Stream 1000 random in-range pairs through ingest -> write_iq -> output words equal source words; count=1000
//  6 reset low during S_WRITE -> strobes 0 immediately (async); after release, first pop pairs new heads

Source files
------------

// File: rtl/write_iq_if.sv
// write_iq handshake bundle: two FWFT input FIFOs and one output FIFO.
// master = write_iq side, slave = FIFO side.
interface write_iq_if;
  logic        inI_rd_en;
  logic        inI_empty;
  logic [31:0] inI_dout;
  logic        inQ_rd_en;
  logic        inQ_empty;
  logic [31:0] inQ_dout;
  logic        out_wr_en;
  logic        out_full;
  logic [63:0] out_din;

  modport master (
    output inI_rd_en, inQ_rd_en, out_wr_en, out_din,
    input  inI_empty, inI_dout, inQ_empty, inQ_dout, out_full
  );

  modport slave (
    input  inI_rd_en, inQ_rd_en, out_wr_en, out_din,
    output inI_empty, inI_dout, inQ_empty, inQ_dout, out_full
  );
endinterface

// File: rtl/write_iq.sv
// write_iq: pops paired fixed-point I/Q samples, dequantizes them and
// pushes one halfword-swapped 64-bit raw IQ word per pair.
module write_iq #(
  parameter int FRAC_BITS = 10,
  parameter int COUNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  write_iq_if.master         bus,
  output logic [COUNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic signed [32:0] HALF =
    33'sd1 <<< (FRAC_BITS - 1);

  state_t             state_q, state_d;
  logic [31:0]        i_q, i_d;
  logic [31:0]        q_q, q_d;
  logic [63:0]        word_q, word_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               rd, wr;

  // Round half up, arithmetic shift; 33 bits so 0x7FFFFFFF cannot overflow.
  function automatic logic [31:0] deq(input logic [31:0] x);
    logic signed [32:0] s;
    s = $signed({x[31], x}) + HALF;
    s = s >>> FRAC_BITS;
    return s[31:0];
  endfunction

  // Halfword swap back into the raw file layout.
  function automatic logic [63:0] pack(
    input logic [31:0] di,
    input logic [31:0] dq
  );
    return {di[15:0], di[31:16], dq[15:0], dq[31:16]};
  endfunction

  // Next state, datapath loads and raw strobes.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    q_d     = q_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_READ: begin
        if (!bus.inI_empty && !bus.inQ_empty) begin
          rd      = 1'b1;
          i_d     = bus.inI_dout;
          q_d     = bus.inQ_dout;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        word_d  = pack(deq(i_q), deq(q_q));
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.out_full) begin
          wr      = 1'b1;
          cnt_d   = cnt_q + COUNT_W'(1);
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_READ;
        i_d     = '0;
        q_d     = '0;
      end
    endcase
  end

  // Strobes are forced low while reset is held, independent of the clock.
  always_comb begin
    bus.inI_rd_en = reset & rd;
    bus.inQ_rd_en = reset & rd;
    bus.out_wr_en = reset & wr;
    bus.out_din   = (reset & wr) ? word_q : 64'd0;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
      i_q     <= '0;
      q_q     <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      q_q     <= q_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sample_count = cnt_q;

endmodule
